// File: rtl/mosq_alarm.sv
// rtl/mosq_alarm.sv - mosquito alarm: input sync, persistence/hold-off FSM, beep cadence, tone, event counter
module mosq_alarm #(
    parameter int ON_CNT    = 64,
    parameter int HOLD_CNT  = 8000,
    parameter int TONE_HALF = 31250,
    parameter int BEEP_ON   = 1600,
    parameter int BEEP_OFF  = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       smp_en,
    input  logic       is_mosq_in,
    input  logic       mute,
    output logic       alarm,
    output logic       buzz,
    output logic       pb_gate,
    output logic [7:0] det_count
);

    localparam int SMAX = (ON_CNT > HOLD_CNT) ? ON_CNT : HOLD_CNT;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int BMAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int TW   = $clog2(TONE_HALF + 1);

    typedef logic [SW-1:0] scnt_t;
    typedef logic [BW-1:0] bcnt_t;
    typedef logic [TW-1:0] tcnt_t;

    localparam scnt_t ON_LAST   = scnt_t'(ON_CNT - 1);
    localparam scnt_t HOLD_LAST = scnt_t'(HOLD_CNT - 1);
    localparam bcnt_t BON_LAST  = bcnt_t'(BEEP_ON - 1);
    localparam bcnt_t BOFF_LAST = bcnt_t'(BEEP_OFF - 1);
    localparam tcnt_t TONE_LAST = tcnt_t'(TONE_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_ALARM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    logic   sync_q1, sync_q2;
    logic   det;
    state_t state_q, state_d;
    scnt_t  scnt_q, scnt_d;
    logic   enter_alarm;
    logic   alarm_q, alarm_d;
    logic [7:0] det_count_q;
    logic   beep_off_q, beep_off_d;
    bcnt_t  bcnt_q, bcnt_d;
    logic   tone_q, tone_d;
    tcnt_t  tcnt_q, tcnt_d;
    logic   buzz_q, buzz_d;

    assign det = sync_q2;

    // two-flop synchroniser for the asynchronous detector flag, runs every clk
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= is_mosq_in;
            sync_q2 <= sync_q1;
        end
    end

    // persistence / hold-off next state, evaluated only on sample strobes
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        enter_alarm = 1'b0;
        if (smp_en) begin
            case (state_q)
                S_IDLE: begin
                    if (det) begin
                        if (ON_CNT == 1) begin
                            state_d     = S_ALARM;
                            scnt_d      = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            state_d = S_ARM;
                            scnt_d  = scnt_t'(1);
                        end
                    end
                end
                S_ARM: begin
                    if (!det) begin
                        state_d = S_IDLE;
                        scnt_d  = '0;
                    end else if (scnt_q == ON_LAST) begin
                        state_d     = S_ALARM;
                        scnt_d      = '0;
                        enter_alarm = 1'b1;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                S_ALARM: begin
                    if (!det) begin
                        if (HOLD_CNT == 1) begin
                            state_d = S_IDLE;
                            scnt_d  = '0;
                        end else begin
                            state_d = S_HOLD;
                            scnt_d  = scnt_t'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (det) begin
                        state_d = S_ALARM;
                        scnt_d  = '0;
                    end else if (scnt_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        scnt_d  = '0;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    scnt_d  = '0;
                end
            endcase
        end
        alarm_d = (state_d == S_ALARM) || (state_d == S_HOLD);
    end

    // FSM state, alarm level and saturating entry counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            scnt_q      <= '0;
            alarm_q     <= 1'b0;
            det_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            alarm_q <= alarm_d;
            if (enter_alarm && (det_count_q != 8'hFF)) begin
                det_count_q <= det_count_q + 1'b1;
            end
        end
    end

    // beep cadence, tone generator and buzzer drive next values
    always_comb begin
        beep_off_d = beep_off_q;
        bcnt_d     = bcnt_q;
        tone_d     = tone_q;
        tcnt_d     = tcnt_q;
        if (!alarm_q) begin
            beep_off_d = 1'b0;
            bcnt_d     = '0;
        end else if (smp_en) begin
            if (beep_off_q ? (bcnt_q == BOFF_LAST) : (bcnt_q == BON_LAST)) begin
                beep_off_d = ~beep_off_q;
                bcnt_d     = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        if (!alarm_q || beep_off_q) begin
            tone_d = 1'b0;
            tcnt_d = '0;
        end else if (tcnt_q == TONE_LAST) begin
            tone_d = ~tone_q;
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
        // gate with the upcoming phase/alarm so buzz is silent for the whole beep-off phase
        buzz_d = tone_q & ~beep_off_d & alarm_d & ~mute;
    end

    // cadence, tone and buzzer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            beep_off_q <= 1'b0;
            bcnt_q     <= '0;
            tone_q     <= 1'b0;
            tcnt_q     <= '0;
            buzz_q     <= 1'b0;
        end else begin
            beep_off_q <= beep_off_d;
            bcnt_q     <= bcnt_d;
            tone_q     <= tone_d;
            tcnt_q     <= tcnt_d;
            buzz_q     <= buzz_d;
        end
    end

    assign alarm     = alarm_q;
    assign pb_gate   = alarm_q;
    assign buzz      = buzz_q;
    assign det_count = det_count_q;

endmodule

// File: tb/tb_mosq_alarm.sv
// tb/tb_mosq_alarm.sv - scoreboard bench for mosq_alarm against a strobe-count reference model
module tb_mosq_alarm;

    localparam int ON   = 4;
    localparam int HOLD = 10;
    localparam int TH   = 3;
    localparam int BON  = 2;
    localparam int BOFF = 2;
    localparam int PER  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       smp_en = 1'b0;
    logic       is_mosq_in = 1'b0;
    logic       mute = 1'b0;
    logic       alarm, buzz, pb_gate;
    logic [7:0] det_count;

    mosq_alarm #(
        .ON_CNT(ON), .HOLD_CNT(HOLD), .TONE_HALF(TH), .BEEP_ON(BON), .BEEP_OFF(BOFF)
    ) dut (
        .clk(clk), .rst(rst), .smp_en(smp_en), .is_mosq_in(is_mosq_in), .mute(mute),
        .alarm(alarm), .buzz(buzz), .pb_gate(pb_gate), .det_count(det_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        bit a;
        bit b;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // reference model: consecutive-strobe runs, edge of alarm rise, strobes since rise
    int now = 0;
    bit d1, d2;
    bit m_alarm;
    int m_cnt, m_run, m_low, m_nstb, m_seg;
    bit m_buzz, m_on;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit det;
        int j;
        if (!rst) begin
            d1 = 0; d2 = 0; m_alarm = 0; m_cnt = 0; m_run = 0; m_low = 0;
            m_nstb = 0; m_seg = 0; m_buzz = 0; m_on = 1;
        end else begin
            det = d2;
            d2  = d1;
            d1  = is_mosq_in;
            if (smp_en) begin
                if (m_alarm) begin
                    m_nstb++;
                    if (m_nstb % (BON + BOFF) == 0) m_seg = now;
                    if (!det) begin
                        m_low++;
                        if (m_low == HOLD) begin
                            m_alarm = 0;
                            m_low = 0;
                            m_run = 0;
                        end
                    end else begin
                        m_low = 0;
                    end
                end else if (det) begin
                    m_run++;
                    if (m_run == ON) begin
                        m_alarm = 1;
                        m_run = 0;
                        m_low = 0;
                        if (m_cnt < 255) m_cnt++;
                        m_nstb = 0;
                        m_seg = now;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_on = (m_nstb % (BON + BOFF)) < BON;
            j = now - 1 - m_seg;
            m_buzz = m_alarm && m_on && !mute && (j >= 0) && (((j / TH) % 2) == 1);
        end
    endtask

    task automatic tick();
        exp_t e;
        smp_en = ((now % PER) == PER - 1);
        model_edge();
        e.edge_no = now;
        e.a = m_alarm;
        e.b = m_buzz;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic strobes(input bit d, input int n);
        int k;
        is_mosq_in = d;
        k = 0;
        while (k < n) begin
            tick();
            if (smp_en) k++;
        end
    endtask

    // monitor: pop the expectation for the edge just taken and compare against the pins
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("alarm", alarm, e.a);
            chk("pb_gate", pb_gate, e.a);
            chk("buzz", buzz, e.b);
            chk("det_count", det_count, e.cnt);
        end
    end

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // persistence: 3 high, 1 low, 4 high
        strobes(1, 3);
        chk("persist_no_alarm", alarm, 0);
        strobes(0, 1);
        strobes(1, 3);
        chk("persist_not_yet", alarm, 0);
        strobes(1, 1);
        chk("persist_alarm", alarm, 1);
        chk("persist_count", det_count, 1);

        // hold-off and re-trigger
        strobes(0, 9);
        chk("hold_gap_alarm", alarm, 1);
        strobes(1, 1);
        strobes(0, 9);
        chk("hold_still", alarm, 1);
        strobes(0, 1);
        chk("hold_fall", alarm, 0);
        chk("hold_count", det_count, 1);

        // cadence while alarm held
        strobes(1, 4);
        strobes(1, 12);
        chk("cadence_pb_gate", pb_gate, 1);

        // mute during beep-on
        for (int i = 0; i < 200 && !m_buzz; i++) tick();
        chk("mute_pre_buzz", buzz, 1);
        mute = 1'b1;
        tick();
        chk("mute_buzz", buzz, 0);
        chk("mute_alarm", alarm, 1);
        repeat (5) tick();
        mute = 1'b0;
        strobes(1, 4);

        // reset mid-alarm while buzzing
        for (int i = 0; i < 200 && !m_buzz; i++) tick();
        chk("rst_pre_buzz", buzz, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_alarm", alarm, 0);
        chk("rst_buzz", buzz, 0);
        chk("rst_count", det_count, 0);
        strobes(0, 1);
        strobes(1, 3);
        chk("rst_retrig_not_yet", alarm, 0);
        strobes(1, 1);
        chk("rst_retrig", alarm, 1);

        // randomized detector and mute activity
        repeat (60) begin
            mute = ($urandom_range(0, 3) == 0);
            strobes($urandom_range(0, 2) != 0, $urandom_range(1, 6));
        end
        mute = 1'b0;

        // saturation of the entry counter
        strobes(0, HOLD);
        repeat (260) begin
            strobes(1, ON);
            strobes(0, HOLD);
        end
        chk("sat_count", det_count, 255);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
